// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for the DataPath: fetch (T0-T2) and execute (T3-T5/T6)
// steps for three-register ALU instructions, with run/halt, memory waits and HI/LO write-back.
module alu_instr_sequencer #(
    parameter int                     DATA_W      = 32,
    parameter int                     NUM_REGS    = 16,
    parameter int                     SEL_W       = 4,
    parameter int                     OPCODE_W    = 5,
    parameter logic [OPCODE_W-1:0]    MUL_OPCODE  = 5'b01111,
    parameter logic [OPCODE_W-1:0]    DIV_OPCODE  = 5'b10000,
    parameter logic [OPCODE_W-1:0]    HALT_OPCODE = 5'b11011
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     ir,
    output logic                  PCout,
    output logic                  IncPC,
    output logic                  MARin,
    output logic                  Zin,
    output logic                  Zlo_out,
    output logic                  Zhi_out,
    output logic                  PCin,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  HIin,
    output logic                  LOin,
    output logic [NUM_REGS-1:0]   Rin,
    output logic [NUM_REGS-1:0]   Rout,
    output logic [OPCODE_W-1:0]   alu_op,
    output logic                  instr_done,
    output logic                  halted,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t cur_state, nxt_state;

    logic [OPCODE_W-1:0] opcode;
    logic [SEL_W-1:0]    ra, rb, rc;
    logic                wide_op;
    logic                unused_ir_bits;

    assign opcode  = ir[DATA_W-1 -: OPCODE_W];
    assign ra      = ir[DATA_W-OPCODE_W-1 -: SEL_W];
    assign rb      = ir[DATA_W-OPCODE_W-SEL_W-1 -: SEL_W];
    assign rc      = ir[DATA_W-OPCODE_W-2*SEL_W-1 -: SEL_W];
    assign wide_op = (opcode == MUL_OPCODE) || (opcode == DIV_OPCODE);
    assign unused_ir_bits = ^ir[DATA_W-OPCODE_W-3*SEL_W-1:0];

    // Field values beyond the register file select nothing.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [SEL_W-1:0] v);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (v == SEL_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) cur_state <= S_IDLE;
        else        cur_state <= nxt_state;
    end

    assign state = cur_state;

    always_comb begin
        nxt_state  = cur_state;
        PCout      = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        Zin        = 1'b0;
        Zlo_out    = 1'b0;
        Zhi_out    = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Rin        = '0;
        Rout       = '0;
        alu_op     = '0;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (cur_state)
            S_IDLE: begin
                if (run) nxt_state = S_T0;
            end
            S_T0: begin
                PCout     = 1'b1;
                IncPC     = 1'b1;
                MARin     = 1'b1;
                Zin       = 1'b1;
                nxt_state = S_T1;
            end
            S_T1: begin
                // Held while memory stalls; reloading PC from Z is harmless.
                Zlo_out = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) nxt_state = S_T2;
            end
            S_T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                nxt_state = S_T3;
            end
            S_T3: begin
                if (opcode == HALT_OPCODE) begin
                    nxt_state = S_HALT;
                end else begin
                    Rout      = reg_sel(rb);
                    Yin       = 1'b1;
                    nxt_state = S_T4;
                end
            end
            S_T4: begin
                Rout      = reg_sel(rc);
                Zin       = 1'b1;
                alu_op    = opcode;
                nxt_state = S_T5;
            end
            S_T5: begin
                Zlo_out = 1'b1;
                alu_op  = opcode;
                if (wide_op) begin
                    LOin      = 1'b1;
                    nxt_state = S_T6;
                end else begin
                    Rin        = reg_sel(ra);
                    instr_done = 1'b1;
                    nxt_state  = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhi_out    = 1'b1;
                HIin       = 1'b1;
                alu_op     = opcode;
                instr_done = 1'b1;
                nxt_state  = run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench: a step-list model of each instruction is checked every cycle,
// alongside hand-computed literal expectations for the directed flows.
module tb_alu_instr_sequencer;

    logic        clock, clear, run, mem_ready;
    logic [31:0] ir;
    logic PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        instr_done, halted;
    logic [3:0]  state;

    alu_instr_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out),
        .Zhi_out(Zhi_out), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .instr_done(instr_done), .halted(halted), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [13:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
        logic        done;
        logic        hlt;
        logic [3:0]  st;
    } exp_t;

    // Strobe bit positions in exp_t.strb
    localparam int B_PCOUT = 13, B_INCPC = 12, B_MARIN = 11, B_ZIN = 10, B_ZLO = 9, B_ZHI = 8,
                   B_PCIN = 7, B_READ = 6, B_MDRIN = 5, B_MDROUT = 4, B_IRIN = 3, B_YIN = 2,
                   B_HIIN = 1, B_LOIN = 0;

    exp_t got_vec;
    assign got_vec = '{strb: {PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read, MDRin,
                              MDRout, IRin, Yin, HIin, LOin},
                       rin: Rin, rout: Rout, op: alu_op, done: instr_done, hlt: halted, st: state};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model: queue of remaining steps ----------------
    exp_t q[$];
    bit   halt_m    = 0;
    bit   halt_pend = 0;

    function automatic exp_t mk(input int st, input logic [13:0] strb, input logic [15:0] rin,
                                input logic [15:0] rout, input logic [4:0] op, input logic done);
        exp_t e;
        e.strb = strb; e.rin = rin; e.rout = rout; e.op = op; e.done = done; e.hlt = 1'b0;
        e.st = 4'(st);
        return e;
    endfunction

    task automatic build_instr();
        logic [4:0]  op;
        logic [15:0] ra_oh, rb_oh, rc_oh;
        op    = ir[31:27];
        ra_oh = 16'd1 << ir[26:23];
        rb_oh = 16'd1 << ir[22:19];
        rc_oh = 16'd1 << ir[18:15];
        q.push_back(mk(1, 14'((1 << B_PCOUT) | (1 << B_INCPC) | (1 << B_MARIN) | (1 << B_ZIN)), 0, 0, 0, 0));
        q.push_back(mk(2, 14'((1 << B_ZLO) | (1 << B_PCIN) | (1 << B_READ) | (1 << B_MDRIN)), 0, 0, 0, 0));
        q.push_back(mk(3, 14'((1 << B_MDROUT) | (1 << B_IRIN)), 0, 0, 0, 0));
        if (op == 5'b11011) begin
            q.push_back(mk(4, 0, 0, 0, 0, 0));
            halt_pend = 1;
        end else begin
            q.push_back(mk(4, 14'(1 << B_YIN), 0, rb_oh, 0, 0));
            q.push_back(mk(5, 14'(1 << B_ZIN), 0, rc_oh, op, 0));
            if (op == 5'b01111 || op == 5'b10000) begin
                q.push_back(mk(6, 14'((1 << B_ZLO) | (1 << B_LOIN)), 0, 0, op, 0));
                q.push_back(mk(7, 14'((1 << B_ZHI) | (1 << B_HIIN)), 0, 0, op, 1));
            end else begin
                q.push_back(mk(6, 14'(1 << B_ZLO), ra_oh, 0, op, 1));
            end
        end
    endtask

    function automatic exp_t exp_now();
        exp_t e;
        e = '0;
        if (halt_m) begin
            e.hlt = 1'b1;
            e.st  = 4'd8;
        end else if (q.size() != 0) begin
            e = q[0];
        end
        return e;
    endfunction

    initial begin : model
        exp_t h;
        forever begin
            @(posedge clock or negedge clear);
            if (!clear) begin
                q.delete();
                halt_m    = 0;
                halt_pend = 0;
            end else if (!halt_m) begin
                if (q.size() == 0) begin
                    if (run) build_instr();
                end else if (!(q[0].st == 4'd2 && !mem_ready)) begin
                    h = q.pop_front();
                    if (q.size() == 0 && halt_pend) begin
                        halt_m    = 1;
                        halt_pend = 0;
                    end else if (h.done && run) begin
                        build_instr();
                    end
                end
            end
        end
    end

    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clock);
            if (clear) begin
                e = exp_now();
                chk("cycle_vs_model", 64'(got_vec), 64'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_run();
        run = 1;
        @(posedge clock); #1;
        run = 0;
    endtask

    task automatic wait_idle(output int cyc, output int t1c);
        cyc = 0;
        t1c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (state == 4'd0) break;
            cyc++;
            if (state == 4'd2 && Read && MDRin) t1c++;
        end
    endtask

    initial begin : stim
        int st_and[6]    = '{1, 2, 3, 4, 5, 6};
        int rout_and[6]  = '{0, 0, 0, 4, 8, 0};
        int rin_and[6]   = '{0, 0, 0, 0, 0, 2};
        int op_and[6]    = '{0, 0, 0, 0, 5, 5};
        int rout_mul[7]  = '{0, 0, 0, 8, 16, 0, 0};
        int op_mul[7]    = '{0, 0, 0, 0, 15, 15, 15};
        int seq[12];
        int cyc, t1c, hcount;

        clock = 0; clear = 0; run = 0; mem_ready = 1; ir = '0;
        #2;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_outputs", 64'(got_vec), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_held", 64'(got_vec), 64'd0);
        clear = 1;

        // AND flow
        ir = 32'h2891_8000;
        pulse_run();
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("and_state", 64'(state), 64'(st_and[k]));
            chk("and_rout", 64'(Rout), 64'(rout_and[k]));
            chk("and_rin", 64'(Rin), 64'(rin_and[k]));
            chk("and_aluop", 64'(alu_op), 64'(op_and[k]));
        end
        chk("and_t0_strobes", 64'(instr_done), 64'd1);
        @(negedge clock);
        chk("and_idle", 64'(state), 64'd0);

        // Memory wait states: mem_ready low for three T1 cycles
        @(posedge clock); #1;
        mem_ready = 0;
        pulse_run();
        fork
            begin
                repeat (4) begin @(posedge clock); #1; end
                mem_ready = 1;
            end
            wait_idle(cyc, t1c);
        join
        chk("memwait_cycles", 64'(cyc), 64'd9);
        chk("memwait_t1_read", 64'(t1c), 64'd4);

        // MUL flow
        @(posedge clock); #1;
        ir = 32'h781A_0000;
        pulse_run();
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            chk("mul_state", 64'(state), 64'(k + 1));
            chk("mul_rout", 64'(Rout), 64'(rout_mul[k]));
            chk("mul_aluop", 64'(alu_op), 64'(op_mul[k]));
            if (k == 5) chk("mul_t5", 64'({Zlo_out, LOin, HIin, instr_done, Rin}), {44'd0, 4'b1100, 16'd0});
            if (k == 6) chk("mul_t6", 64'({Zhi_out, HIin, LOin, instr_done}), 64'b1101);
        end
        @(negedge clock);
        chk("mul_idle", 64'(state), 64'd0);

        // DIV takes the HI/LO path too
        @(posedge clock); #1;
        ir = {5'b10000, 4'd5, 4'd6, 4'd7, 15'd0};
        pulse_run();
        wait_idle(cyc, t1c);
        chk("div_cycles", 64'(cyc), 64'd7);

        // Back-to-back with run held high
        @(posedge clock); #1;
        ir = 32'h2891_8000;
        run = 1;
        @(posedge clock); #1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            seq[k] = int'(state);
            if (k == 11) run = 0;
        end
        chk("b2b_first_t5", 64'(seq[5]), 64'd6);
        chk("b2b_second_t0", 64'(seq[6]), 64'd1);
        chk("b2b_second_t5", 64'(seq[11]), 64'd6);
        @(negedge clock);
        chk("b2b_idle", 64'(state), 64'd0);

        // Asynchronous clear during T4
        @(posedge clock); #1;
        pulse_run();
        repeat (5) @(negedge clock);
        chk("t4_reached", 64'(state), 64'd5);
        #2 clear = 0;
        #1;
        chk("async_clear_state", 64'(state), 64'd0);
        chk("async_clear_outputs", 64'(got_vec), 64'd0);
        #1 clear = 1;
        @(negedge clock);
        chk("after_clear_idle", 64'(state), 64'd0);

        // HALT: run ignored until clear
        @(posedge clock); #1;
        ir = 32'hD800_0000;
        pulse_run();
        repeat (4) @(negedge clock);
        chk("halt_t3_quiet", 64'({Rout, Yin, state}), 64'd4);
        @(negedge clock);
        chk("halt_state", 64'({halted, state}), 64'h18);
        run = 1;
        hcount = 0;
        repeat (10) begin
            @(negedge clock);
            if (state == 4'd8 && halted) hcount++;
        end
        chk("halt_run_ignored", 64'(hcount), 64'd10);
        #2 clear = 0;
        #1;
        chk("halt_clear", 64'({halted, state}), 64'd0);
        run = 0;
        #1 clear = 1;
        repeat (2) @(negedge clock);
        chk("halt_exit_idle", 64'(got_vec), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Synthesizable control-step sequencer for the DataPath: it replaces hand-written per-instruction stimulus FSMs with one parametrised Moore machine. Per instruction it generates the fetch steps T0–T2 and the execute steps T3–T5/T6 for three-register ALU instructions. It adds features the hand sequences lack:
- run/halt handshake;
- memory wait states;
- one-hot register-select vectors decoded from the IR;
- a HI/LO write-back mode for multiply/divide.

## Interface
- DATA_W, 32, IR/data width
- NUM_REGS, 16, general-purpose register count; must be ≤ 2**SEL_W
- SEL_W, 4, register-field width
- OPCODE_W, 5, opcode field width, IR[DATA_W-1 -: OPCODE_W]
- MUL_OPCODE, 5'b01111, opcode taking HI/LO write-back
- DIV_OPCODE, 5'b10000, opcode taking HI/LO write-back
- HALT_OPCODE, 5'b11011, opcode entering HALT

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  reset, asynchronous, active-low
- run  in  1  start/continue request, sampled at IDLE and at the final execute step
- mem_ready  in  1  memory read data valid on MDR_Mem_lines
- ir  in  DATA_W  IR_VALUE from the datapath. Fields: Ra = next SEL_W bits below the opcode, then Rb, then Rc.
- PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes
- Rin  out  NUM_REGS  one-hot register load enables
- Rout  out  NUM_REGS  one-hot register bus drives
- alu_op  out  OPCODE_W  ALU opcode
- instr_done  out  1  high during the final step of each instruction
- halted  out  1  sequencer in HALT
- state  out  4  current state: IDLE=0, T0..T6=1..7, HALT=8

## Operation
- Moore machine: every output is a decode of the registered state and of `ir` only.
- Reset (clear=0): state=IDLE and every output 0, asynchronously, including in mid-instruction.
- Default for any strobe not listed for a state: 0.
- IDLE: no strobes asserted. run=1 → T0.
- T0: PCout, IncPC, MARin, Zin → T1.
- T1: Zlo_out, PCin, Read, MDRin.
  - mem_ready=0: remain in T1 with all four held (PC reload is idempotent).
  - mem_ready=1: → T2.
- T2: MDRout, IRin → T3.
- T3:
  - opcode==HALT_OPCODE: no strobes; → HALT.
  - Otherwise: Rout[Rb], Yin → T4.
- T4: Rout[Rc], Zin, alu_op=opcode → T5.
- T5, normal opcode: Zlo_out, Rin[Ra], alu_op=opcode, instr_done. Then run=1 → T0, else → IDLE.
- T5, MUL_OPCODE/DIV_OPCODE: Zlo_out, LOin, alu_op=opcode; Rin=0. → T6.
- T6: Zhi_out, HIin, alu_op=opcode, instr_done. Then run=1 → T0, else → IDLE.
- HALT: halted=1, all strobes 0. Exit only via clear; run is ignored.
- alu_op is 0 outside T4–T6.
- Register select: field value v drives bit v of Rin/Rout. If v ≥ NUM_REGS, no bit is asserted and no error is flagged.
- run deasserted mid-instruction: the current instruction completes; run is checked only at the final step.
- Unused state encodings: → IDLE on the next clock edge, outputs 0.

## Timing
- ALU instruction with mem_ready=1: 6 cycles (T0–T5).
- MUL/DIV: 7 cycles.
- Each mem_ready=0 cycle in T1 adds one cycle.
- Back-to-back with run held high: final step → T0 with zero idle cycles.
- IR contents are valid from T3, after the IRin edge at the end of T2. Rb/Rc/Ra decode uses `ir` as seen in T3–T6.
- Each strobe is asserted for whole clock cycles. The datapath captures on the rising edge that ends the state.

## Test plan
- Reset: hold clear=0 → state=0, every output 0. Assert clear=0 during T4 → all outputs 0 immediately, without waiting for a clock edge; state=0.
- AND flow: ir=0x28918000 (opcode 5, Ra=1, Rb=2, Rc=3), mem_ready=1, run pulsed one cycle. Required sequence:
  - T0: PCout, IncPC, MARin, Zin.
  - T1: Zlo_out, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: Rout=0x0004, Yin.
  - T4: Rout=0x0008, Zin, alu_op=5.
  - T5: Rin=0x0002, Zlo_out, instr_done.
  - Then IDLE; 6 cycles total.
- Memory wait: same ir, mem_ready=0 for the first 3 T1 cycles → T1 lasts 4 cycles with Read/MDRin held throughout; 9 cycles total.
- MUL flow: ir=0x781A0000 (opcode 01111, Rb=3, Rc=4):
  - T3: Rout=0x0008.
  - T4: Rout=0x0010, alu_op=0x0F.
  - T5: Zlo_out+LOin, Rin=0.
  - T6: Zhi_out+HIin, instr_done.
- Back-to-back and halt:
  - run held high, two ALU instructions → second T0 directly follows the first T5.
  - ir=0xD8000000 → HALT after T3: halted=1, state=8, run ignored for 10 cycles.
  - clear pulse → IDLE.
